// File: rtl/stream_mux.sv
// N-channel valid/ready packet multiplexer with a registered output stage.
// A channel is granted by sel (MODE 0) or round-robin (MODE 1) and holds the output until its last beat.
module stream_mux #(
  parameter int unsigned N_CH  = 4,
  parameter int unsigned WIDTH = 8,
  parameter int unsigned MODE  = 0,
  parameter int unsigned CH_W  = $clog2(N_CH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [N_CH*WIDTH-1:0] in_data,
  input  logic [N_CH-1:0]       in_valid,
  input  logic [N_CH-1:0]       in_last,
  output logic [N_CH-1:0]       in_ready,
  input  logic [CH_W-1:0]       sel,
  output logic [WIDTH-1:0]      out_data,
  output logic                  out_valid,
  output logic                  out_last,
  input  logic                  out_ready,
  output logic                  busy,
  output logic [CH_W-1:0]       cur_ch
);

  localparam logic [0:0] StIdle   = 1'b0;
  localparam logic [0:0] StLocked = 1'b1;

  logic [0:0]       state_q, state_d;
  logic [CH_W-1:0]  cur_ch_q, cur_ch_d;
  logic [CH_W-1:0]  rr_ptr_q, rr_ptr_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic             out_valid_q, out_valid_d;
  logic             out_last_q, out_last_d;

  logic             req;
  logic [CH_W-1:0]  cand;
  logic             found_hi, found_lo;
  logic [CH_W-1:0]  cand_hi, cand_lo;
  logic             cur_valid, cur_last;
  logic [WIDTH-1:0] cur_data;
  logic             space;
  logic             accept;

  // Candidate selection for the IDLE cycle.
  always_comb begin
    req      = 1'b0;
    cand     = '0;
    found_hi = 1'b0;
    found_lo = 1'b0;
    cand_hi  = '0;
    cand_lo  = '0;
    if (MODE == 0) begin
      cand = sel;
      // A sel value >= N_CH matches no channel and therefore never requests.
      for (int i = 0; i < int'(N_CH); i++) begin
        if (sel == CH_W'(i) && in_valid[i]) req = 1'b1;
      end
    end else begin
      // Scan rr_ptr+1 .. N_CH-1 first, then wrap to 0 .. rr_ptr.
      for (int i = 0; i < int'(N_CH); i++) begin
        if (!found_hi && in_valid[i] && (CH_W'(i) > rr_ptr_q)) begin
          found_hi = 1'b1;
          cand_hi  = CH_W'(i);
        end
        if (!found_lo && in_valid[i]) begin
          found_lo = 1'b1;
          cand_lo  = CH_W'(i);
        end
      end
      req  = found_hi | found_lo;
      cand = found_hi ? cand_hi : cand_lo;
    end
  end

  // Granted-channel datapath and handshake.
  always_comb begin
    cur_valid = 1'b0;
    cur_last  = 1'b0;
    cur_data  = '0;
    in_ready  = '0;
    space     = !out_valid_q || out_ready;
    for (int i = 0; i < int'(N_CH); i++) begin
      if (cur_ch_q == CH_W'(i)) begin
        cur_valid   = in_valid[i];
        cur_last    = in_last[i];
        cur_data    = in_data[i*WIDTH +: WIDTH];
        in_ready[i] = (state_q == StLocked) && space;
      end
    end
    accept = (state_q == StLocked) && space && cur_valid;
  end

  always_comb begin
    state_d     = state_q;
    cur_ch_d    = cur_ch_q;
    rr_ptr_d    = rr_ptr_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    unique case (state_q)
      StIdle: begin
        if (req) begin
          state_d  = StLocked;
          cur_ch_d = cand;
          if (MODE != 0) rr_ptr_d = cand;
        end
      end
      StLocked: begin
        if (accept && cur_last) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
    if (accept) begin
      out_data_d  = cur_data;
      out_last_d  = cur_last;
      out_valid_d = 1'b1;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      cur_ch_q    <= '0;
      rr_ptr_q    <= CH_W'(N_CH - 1);
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cur_ch_q    <= cur_ch_d;
      rr_ptr_q    <= rr_ptr_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;
  assign busy      = (state_q == StLocked);
  assign cur_ch    = cur_ch_q;

endmodule

// File: tb/tb_stream_mux.sv
// Directed bench for stream_mux: select mode, round-robin mode and a 3-channel out-of-range sel.
module tb_stream_mux;

  logic clk;
  logic rst_n;

  // MODE 0, 4 channels
  logic [31:0] d0_in_data;
  logic [3:0]  d0_in_valid, d0_in_last, d0_in_ready;
  logic [1:0]  d0_sel, d0_cur_ch;
  logic [7:0]  d0_out_data;
  logic        d0_out_valid, d0_out_last, d0_out_ready, d0_busy;

  // MODE 1, 4 channels
  logic [31:0] d1_in_data;
  logic [3:0]  d1_in_valid, d1_in_last, d1_in_ready;
  logic [1:0]  d1_sel, d1_cur_ch;
  logic [7:0]  d1_out_data;
  logic        d1_out_valid, d1_out_last, d1_out_ready, d1_busy;

  // MODE 0, 3 channels
  logic [23:0] d3_in_data;
  logic [2:0]  d3_in_valid, d3_in_last, d3_in_ready;
  logic [1:0]  d3_sel, d3_cur_ch;
  logic [7:0]  d3_out_data;
  logic        d3_out_valid, d3_out_last, d3_out_ready, d3_busy;

  int n_total;
  int n_pass;

  stream_mux #(.N_CH(4), .WIDTH(8), .MODE(0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .in_data(d0_in_data), .in_valid(d0_in_valid),
    .in_last(d0_in_last), .in_ready(d0_in_ready), .sel(d0_sel), .out_data(d0_out_data),
    .out_valid(d0_out_valid), .out_last(d0_out_last), .out_ready(d0_out_ready),
    .busy(d0_busy), .cur_ch(d0_cur_ch)
  );

  stream_mux #(.N_CH(4), .WIDTH(8), .MODE(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .in_data(d1_in_data), .in_valid(d1_in_valid),
    .in_last(d1_in_last), .in_ready(d1_in_ready), .sel(d1_sel), .out_data(d1_out_data),
    .out_valid(d1_out_valid), .out_last(d1_out_last), .out_ready(d1_out_ready),
    .busy(d1_busy), .cur_ch(d1_cur_ch)
  );

  stream_mux #(.N_CH(3), .WIDTH(8), .MODE(0)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .in_data(d3_in_data), .in_valid(d3_in_valid),
    .in_last(d3_in_last), .in_ready(d3_in_ready), .sel(d3_sel), .out_data(d3_out_data),
    .out_valid(d3_out_valid), .out_last(d3_out_last), .out_ready(d3_out_ready),
    .busy(d3_busy), .cur_ch(d3_cur_ch)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    else n_pass++;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_total = 0;
    n_pass  = 0;
    rst_n   = 1'b0;
    d0_in_data = '0; d0_in_valid = '0; d0_in_last = '0; d0_sel = '0; d0_out_ready = 1'b1;
    d1_in_data = {8'h13, 8'h12, 8'h11, 8'h10};
    d1_in_valid = '0; d1_in_last = 4'b1111; d1_sel = '0; d1_out_ready = 1'b1;
    d3_in_data = {8'h33, 8'h32, 8'h31}; d3_in_valid = 3'b111; d3_in_last = 3'b111;
    d3_sel = 2'd3; d3_out_ready = 1'b1;
    tick();
    tick();
    check("rst0_out_valid", 32'(d0_out_valid), 32'd0);
    check("rst0_busy", 32'(d0_busy), 32'd0);
    check("rst0_cur_ch", 32'(d0_cur_ch), 32'd0);
    check("rst0_in_ready", 32'(d0_in_ready), 32'd0);
    check("rst0_out_data", 32'(d0_out_data), 32'd0);
    check("rst1_busy", 32'(d1_busy), 32'd0);
    check("rst3_in_ready", 32'(d3_in_ready), 32'd0);
    rst_n = 1'b1;

    // 3-beat packet on channel 2
    d0_sel = 2'd2; d0_in_valid = 4'b0100; d0_in_data[23:16] = 8'hA1;
    tick();
    check("t1_grant_busy", 32'(d0_busy), 32'd1);
    check("t1_grant_cur", 32'(d0_cur_ch), 32'd2);
    check("t1_grant_ready", 32'(d0_in_ready), 32'b0100);
    check("t1_bubble_valid", 32'(d0_out_valid), 32'd0);
    tick();
    check("t1_b1_valid", 32'(d0_out_valid), 32'd1);
    check("t1_b1_data", 32'(d0_out_data), 32'hA1);
    check("t1_b1_last", 32'(d0_out_last), 32'd0);
    d0_in_data[23:16] = 8'hA2;
    tick();
    check("t1_b2_data", 32'(d0_out_data), 32'hA2);
    check("t1_b2_last", 32'(d0_out_last), 32'd0);
    d0_in_data[23:16] = 8'hA3; d0_in_last = 4'b0100;
    tick();
    check("t1_b3_data", 32'(d0_out_data), 32'hA3);
    check("t1_b3_last", 32'(d0_out_last), 32'd1);
    check("t1_b3_busy", 32'(d0_busy), 32'd0);
    d0_in_valid = '0; d0_in_last = '0;
    tick();
    check("t1_drain_valid", 32'(d0_out_valid), 32'd0);

    // sel moves 2->0 mid-packet
    d0_in_valid = 4'b0101; d0_in_data[23:16] = 8'hB1; d0_in_data[7:0] = 8'hC1;
    d0_in_last = 4'b0001;
    tick();
    check("t2_grant_cur", 32'(d0_cur_ch), 32'd2);
    d0_sel = 2'd0;
    tick();
    check("t2_b1_data", 32'(d0_out_data), 32'hB1);
    check("t2_b1_cur", 32'(d0_cur_ch), 32'd2);
    d0_in_data[23:16] = 8'hB2; d0_in_last = 4'b0101;
    tick();
    check("t2_b2_data", 32'(d0_out_data), 32'hB2);
    check("t2_b2_last", 32'(d0_out_last), 32'd1);
    check("t2_b2_busy", 32'(d0_busy), 32'd0);
    d0_in_valid = 4'b0001;
    tick();
    check("t2_ch0_busy", 32'(d0_busy), 32'd1);
    check("t2_ch0_cur", 32'(d0_cur_ch), 32'd0);
    check("t2_ch0_bubble", 32'(d0_out_valid), 32'd0);
    tick();
    check("t2_c1_data", 32'(d0_out_data), 32'hC1);
    check("t2_c1_last", 32'(d0_out_last), 32'd1);
    d0_in_valid = '0; d0_in_last = '0;

    // Backpressure mid-packet on channel 1
    d0_sel = 2'd1; d0_in_valid = 4'b0010; d0_in_data[15:8] = 8'hD1;
    tick();
    check("t4_grant_cur", 32'(d0_cur_ch), 32'd1);
    tick();
    check("t4_d1_data", 32'(d0_out_data), 32'hD1);
    d0_out_ready = 1'b0; d0_in_data[15:8] = 8'hD2;
    #1;
    check("t4_full_ready", 32'(d0_in_ready), 32'd0);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("t4_hold_data", 32'(d0_out_data), 32'hD1);
      check("t4_hold_valid", 32'(d0_out_valid), 32'd1);
      check("t4_hold_ready", 32'(d0_in_ready), 32'd0);
    end
    d0_out_ready = 1'b1;
    #1;
    check("t4_resume_ready", 32'(d0_in_ready), 32'b0010);
    tick();
    check("t4_d2_data", 32'(d0_out_data), 32'hD2);
    d0_in_data[15:8] = 8'hD3;
    tick();
    check("t4_d3_data", 32'(d0_out_data), 32'hD3);
    d0_in_data[15:8] = 8'hD4; d0_in_last = 4'b0010;
    tick();
    check("t4_d4_data", 32'(d0_out_data), 32'hD4);
    check("t4_d4_last", 32'(d0_out_last), 32'd1);
    check("t4_d4_busy", 32'(d0_busy), 32'd0);
    d0_in_valid = '0; d0_in_last = '0;
    tick();
    check("t4_drain_valid", 32'(d0_out_valid), 32'd0);

    // Round-robin over four single-beat channels
    d1_in_valid = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      tick();
      check("t3_grant_cur", 32'(d1_cur_ch), 32'(k % 4));
      check("t3_grant_busy", 32'(d1_busy), 32'd1);
      check("t3_bubble_valid", 32'(d1_out_valid), 32'd0);
      tick();
      check("t3_beat_valid", 32'(d1_out_valid), 32'd1);
      check("t3_beat_data", 32'(d1_out_data), 32'h10 + 32'(k % 4));
      check("t3_beat_last", 32'(d1_out_last), 32'd1);
      check("t3_beat_busy", 32'(d1_busy), 32'd0);
    end

    // Reset during beat 2 of a channel-2 packet
    d1_in_valid = 4'b0100; d1_in_last = 4'b0000;
    tick();
    check("t5_grant_cur", 32'(d1_cur_ch), 32'd2);
    tick();
    check("t5_b1_data", 32'(d1_out_data), 32'h12);
    rst_n = 1'b0;
    tick();
    check("t5_rst_valid", 32'(d1_out_valid), 32'd0);
    check("t5_rst_busy", 32'(d1_busy), 32'd0);
    check("t5_rst_cur", 32'(d1_cur_ch), 32'd0);
    check("t5_rst_ready", 32'(d1_in_ready), 32'd0);
    rst_n = 1'b1;
    // ch3 would win if the pointer had survived at 2
    d1_in_valid = 4'b1101; d1_in_last = 4'b1111;
    tick();
    check("t5_first_cur", 32'(d1_cur_ch), 32'd0);
    check("t5_first_busy", 32'(d1_busy), 32'd1);
    tick();
    check("t5_first_data", 32'(d1_out_data), 32'h10);
    d1_in_valid = 4'b0001;
    tick();
    check("t5_wrap_cur", 32'(d1_cur_ch), 32'd0);
    check("t5_wrap_busy", 32'(d1_busy), 32'd1);
    tick();
    check("t5_wrap_data", 32'(d1_out_data), 32'h10);
    d1_in_valid = '0;

    // 3 channels with sel=3: never granted
    for (int i = 0; i < 10; i++) begin
      tick();
      check("t6_busy", 32'(d3_busy), 32'd0);
      check("t6_ready", 32'(d3_in_ready), 32'd0);
      check("t6_valid", 32'(d3_out_valid), 32'd0);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
